// File: rtl/calc_pkg.sv
// Shared opcode and FSM-state encodings for the handshaked register-file calculator.
package calc_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_ADC = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_MUL  = 2'd2;

endpackage

// File: rtl/calc_regfile.sv
// NUM_REGS x DATA_W register file: two async read ports, one sync write port, async clear.
module calc_regfile #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra_x,
  input  logic [ADDR_W-1:0] ra_y,
  output logic [DATA_W-1:0] rd_x,
  output logic [DATA_W-1:0] rd_y
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)                            regs[i] <= '0;
      else if (we && wa == ADDR_W'(i))       regs[i] <= wd;
    end
  end

  assign rd_x = regs[ra_x];
  assign rd_y = regs[ra_y];

endmodule

// File: rtl/param_calculator.sv
// Handshaked register-file calculator: single-cycle ALU ops plus a DATA_W-cycle
// shift-add multiplier, with writeback and a persistent Carry flag.
module param_calculator
  import calc_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              WEN,
  input  logic [ADDR_W-1:0] RW,
  input  logic [ADDR_W-1:0] RX,
  input  logic [ADDR_W-1:0] RY,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Sel,
  input  logic [3:0]        Ctrl,
  output logic [DATA_W-1:0] Result,
  output logic              res_valid,
  output logic              Carry
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] rw;
    logic [3:0]        op;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } cmd_t;

  logic [1:0]          state;
  cmd_t                cmd_q;
  logic [DATA_W-1:0]   rd_x, rd_y, x_in;
  logic                accept, done;

  logic [2*DATA_W-1:0] acc, mcand, acc_nx;
  logic [DATA_W-1:0]   mplier;
  logic [CNT_W-1:0]    cnt;

  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   alu_res, res_nx;
  logic                alu_c, c_nx;

  assign cmd_ready = (state == ST_IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign x_in      = Sel ? rd_x : DataIn;

  calc_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_rf (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .we   (done & cmd_q.wen),
    .wa   (cmd_q.rw),
    .wd   (res_nx),
    .ra_x (RX),
    .ra_y (RY),
    .rd_x (rd_x),
    .rd_y (rd_y)
  );

  always_comb begin
    sum     = '0;
    alu_res = cmd_q.x;
    alu_c   = 1'b0;
    case (cmd_q.op)
      OP_ADD: begin
        sum     = {1'b0, cmd_q.x} + {1'b0, cmd_q.y};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_ADC: begin
        sum     = {1'b0, cmd_q.x} + {1'b0, cmd_q.y} + {{DATA_W{1'b0}}, Carry};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      // The wrapped-around top bit of the extended difference is the borrow.
      OP_SUB: begin
        sum     = {1'b0, cmd_q.x} - {1'b0, cmd_q.y};
        alu_res = sum[DATA_W-1:0];
        alu_c   = sum[DATA_W];
      end
      OP_AND: alu_res = cmd_q.x & cmd_q.y;
      OP_OR:  alu_res = cmd_q.x | cmd_q.y;
      OP_XOR: alu_res = cmd_q.x ^ cmd_q.y;
      OP_NOT: alu_res = ~cmd_q.x;
      OP_SLL: begin
        alu_res = {cmd_q.x[DATA_W-2:0], 1'b0};
        alu_c   = cmd_q.x[DATA_W-1];
      end
      OP_SRL: begin
        alu_res = {1'b0, cmd_q.x[DATA_W-1:1]};
        alu_c   = cmd_q.x[0];
      end
      default: ;
    endcase
  end

  // Last multiply iteration and completion share an edge, so use the next accumulator.
  assign acc_nx = acc + (mplier[0] ? mcand : '0);
  assign done   = (state == ST_EXEC) || (state == ST_MUL && cnt == CNT_LAST);
  assign res_nx = (state == ST_MUL) ? acc_nx[DATA_W-1:0] : alu_res;
  assign c_nx   = (state == ST_MUL) ? |acc_nx[2*DATA_W-1:DATA_W] : alu_c;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= ST_IDLE;
      cmd_q     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      Result    <= '0;
      Carry     <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= done;
      if (done) begin
        Result <= res_nx;
        Carry  <= c_nx;
      end
      case (state)
        ST_IDLE: if (accept) begin
          cmd_q  <= '{wen: WEN, rw: RW, op: Ctrl, x: x_in, y: rd_y};
          acc    <= '0;
          mcand  <= {{DATA_W{1'b0}}, x_in};
          mplier <= rd_y;
          cnt    <= '0;
          state  <= (Ctrl == OP_MUL) ? ST_MUL : ST_EXEC;
        end
        ST_EXEC: state <= ST_IDLE;
        ST_MUL: begin
          acc    <= acc_nx;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_calculator.sv
// Directed, table-driven bench for param_calculator (DATA_W=8, NUM_REGS=8).
module tb_param_calculator;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       WEN = 1'b0;
  logic [2:0] RW = '0, RX = '0, RY = '0;
  logic [7:0] DataIn = '0;
  logic       Sel = 1'b0;
  logic [3:0] Ctrl = '0;
  logic [7:0] Result;
  logic       res_valid;
  logic       Carry;

  int nchk = 0;
  int nfail = 0;

  param_calculator #(.DATA_W(8), .NUM_REGS(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .WEN(WEN), .RW(RW), .RX(RX), .RY(RY), .DataIn(DataIn), .Sel(Sel), .Ctrl(Ctrl),
    .Result(Result), .res_valid(res_valid), .Carry(Carry)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      nm;
    logic       wen;
    logic [2:0] rw, rx, ry;
    logic [7:0] din;
    logic       sel;
    logic [3:0] ctrl;
    logic [7:0] er;
    logic       ec;
    bit         chk_c;
    int         lat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic wen, logic [2:0] rw, logic [2:0] rx,
                              logic [2:0] ry, logic [7:0] din, logic sel, logic [3:0] ctrl,
                              logic [7:0] er, logic ec, bit chk_c, int lat);
    vec_t v;
    v.nm = nm; v.wen = wen; v.rw = rw; v.rx = rx; v.ry = ry; v.din = din; v.sel = sel;
    v.ctrl = ctrl; v.er = er; v.ec = ec; v.chk_c = chk_c; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one command, wait for acceptance and completion; lat = edges from accept to res_valid.
  task automatic issue(input logic wen, input logic [2:0] rw, input logic [2:0] rx,
                       input logic [2:0] ry, input logic [7:0] din, input logic sel,
                       input logic [3:0] ctrl, output int lat);
    int n;
    @(negedge Clk);
    WEN = wen; RW = rw; RX = rx; RY = ry; DataIn = din; Sel = sel; Ctrl = ctrl;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge Clk); n++; end
    @(negedge Clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 100) begin @(negedge Clk); lat++; end
    if (!res_valid) lat = -1;
  endtask

  task automatic readreg(input logic [2:0] r, output logic [7:0] val, output int lat);
    issue(1'b0, 3'd0, r, 3'd0, 8'h00, 1'b1, 4'd10, lat);
    val = Result;
  endtask

  initial begin
    int lat;
    logic [7:0] rv;

    tbl.push_back(mk("add_imm",    1, 1, 0, 0, 8'hC8, 0, 4'd0,  8'hC8, 0, 1, 1));
    tbl.push_back(mk("add_carry",  1, 2, 1, 1, 8'h00, 1, 4'd0,  8'h90, 1, 1, 1));
    tbl.push_back(mk("adc",        1, 3, 1, 0, 8'h00, 1, 4'd8,  8'hC9, 0, 1, 1));
    tbl.push_back(mk("rd_reg3",    0, 0, 3, 0, 8'h00, 1, 4'd10, 8'hC9, 0, 1, 1));
    tbl.push_back(mk("ld_reg4",    1, 4, 0, 0, 8'h03, 0, 4'd0,  8'h03, 0, 1, 1));
    tbl.push_back(mk("ld_reg5",    1, 5, 0, 0, 8'h05, 0, 4'd0,  8'h05, 0, 1, 1));
    tbl.push_back(mk("sub_borrow", 0, 0, 4, 5, 8'h00, 1, 4'd1,  8'hFE, 1, 1, 1));
    tbl.push_back(mk("srl",        0, 0, 4, 0, 8'h00, 1, 4'd7,  8'h01, 1, 1, 1));
    tbl.push_back(mk("not",        0, 0, 4, 0, 8'h00, 1, 4'd5,  8'hFC, 0, 1, 1));
    tbl.push_back(mk("and",        0, 0, 1, 3, 8'h00, 1, 4'd2,  8'hC8, 0, 0, 1));
    tbl.push_back(mk("or",         0, 0, 4, 5, 8'h00, 1, 4'd3,  8'h07, 0, 0, 1));
    tbl.push_back(mk("xor",        0, 0, 1, 3, 8'h00, 1, 4'd4,  8'h01, 0, 0, 1));
    tbl.push_back(mk("sll",        0, 0, 1, 0, 8'h00, 1, 4'd6,  8'h90, 1, 1, 1));
    tbl.push_back(mk("adc_cin",    0, 0, 0, 4, 8'hFF, 0, 4'd8,  8'h03, 1, 1, 1));
    tbl.push_back(mk("add_nowen",  0, 1, 0, 1, 8'h7F, 0, 4'd0,  8'h47, 1, 1, 1));
    tbl.push_back(mk("rd_reg1",    0, 0, 1, 0, 8'h00, 1, 4'd10, 8'hC8, 0, 1, 1));
    tbl.push_back(mk("add_selfrw", 1, 1, 1, 1, 8'h00, 1, 4'd0,  8'h90, 1, 1, 1));
    tbl.push_back(mk("rd_reg1b",   0, 0, 1, 0, 8'h00, 1, 4'd10, 8'h90, 0, 1, 1));
    tbl.push_back(mk("reserved",   1, 7, 0, 0, 8'hA5, 0, 4'd15, 8'hA5, 0, 1, 1));
    tbl.push_back(mk("rd_reg7",    0, 0, 7, 0, 8'h00, 1, 4'd10, 8'hA5, 0, 1, 1));
    tbl.push_back(mk("mul_big",    0, 0, 0, 7, 8'hFF, 0, 4'd9,  8'h5B, 1, 1, 8));
    tbl.push_back(mk("mul_zero",   0, 0, 0, 0, 8'hFF, 0, 4'd9,  8'h00, 0, 1, 8));

    // Reset state
    repeat (2) @(negedge Clk);
    chk("rst_result", Result, 8'h00);
    chk("rst_carry", Carry, 1'b0);
    chk("rst_resvalid", res_valid, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    Rst_n = 1'b1;

    // Reset in the middle of a multiply aborts it with no writeback
    issue(1, 6, 0, 0, 8'h10, 0, 4'd0, lat);
    issue(1, 7, 0, 0, 8'h11, 0, 4'd0, lat);
    @(negedge Clk);
    WEN = 1; RW = 2; RX = 6; RY = 7; Sel = 1; Ctrl = 4'd9; cmd_valid = 1'b1;
    @(negedge Clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge Clk);
    chk("mid_mul_busy", cmd_ready, 1'b0);
    #2 Rst_n = 1'b0;
    #1;
    chk("abort_result", Result, 8'h00);
    chk("abort_carry", Carry, 1'b0);
    chk("abort_resvalid", res_valid, 1'b0);
    chk("abort_ready", cmd_ready, 1'b1);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("abort_no_done", res_valid, 1'b0);
    end
    for (int r = 0; r < 8; r++) begin
      readreg(3'(r), rv, lat);
      chk($sformatf("abort_reg%0d", r), rv, 8'h00);
    end

    // Table-driven vectors
    foreach (tbl[i]) begin
      issue(tbl[i].wen, tbl[i].rw, tbl[i].rx, tbl[i].ry, tbl[i].din, tbl[i].sel, tbl[i].ctrl, lat);
      chk({tbl[i].nm, "_lat"}, lat, tbl[i].lat);
      chk({tbl[i].nm, "_res"}, Result, tbl[i].er);
      if (tbl[i].chk_c) chk({tbl[i].nm, "_c"}, Carry, tbl[i].ec);
    end

    // Carry persists across idle cycles (last multiply left it 0; set it to 1 first)
    issue(0, 0, 0, 0, 8'hFF, 0, 4'd6, lat);
    repeat (5) @(negedge Clk);
    chk("carry_hold", Carry, 1'b1);

    // Multiply with cmd_valid held high; next held command is accepted back-to-back
    issue(1, 6, 0, 0, 8'h10, 0, 4'd0, lat);
    issue(1, 7, 0, 0, 8'h11, 0, 4'd0, lat);
    @(negedge Clk);
    WEN = 1; RW = 0; RX = 6; RY = 7; Sel = 1; Ctrl = 4'd9; cmd_valid = 1'b1;
    chk("mul_ready_pre", cmd_ready, 1'b1);
    @(negedge Clk);
    WEN = 0; RX = 0; Ctrl = 4'd10;
    for (int i = 0; i < 8; i++) begin
      chk("mul_busy", cmd_ready, 1'b0);
      chk("mul_no_vld", res_valid, 1'b0);
      if (i < 7) @(negedge Clk);
    end
    @(negedge Clk);
    chk("mul_vld", res_valid, 1'b1);
    chk("mul_res", Result, 8'h10);
    chk("mul_c", Carry, 1'b1);
    chk("mul_ready_post", cmd_ready, 1'b1);
    @(negedge Clk);
    cmd_valid = 1'b0;
    chk("b2b_accepted", cmd_ready, 1'b0);
    chk("b2b_vld_drop", res_valid, 1'b0);
    @(negedge Clk);
    chk("b2b_vld", res_valid, 1'b1);
    chk("b2b_fwd_res", Result, 8'h10);
    chk("b2b_c", Carry, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
